pixel_stream_packer: RTL and testbench
======================================

// Module: pixel_stream_packer
// PURPOSE
//  Downstream of the iteration-to-colour LUT: captures one batch of NUM_ENGINES RGB values (one per engine,
//  consecutive pixels in raster order) and serialises it onto a ready/valid video stream, one pixel per cycle.
//  Tracks raster position and generates start-of-frame (sof) and end-of-line (eol) markers for the video output.
//  Batch in, pixel out, with back-to-back batches at full throughput.
// PARAMETERS
//  RGB_SIZE     24   bits per pixel, {R,G,B}, passed through unchanged
//  NUM_ENGINES  6    pixels per input batch; element 0 is the leftmost pixel
//  IMG_WIDTH    640  pixels per line
//  IMG_HEIGHT   480  lines per frame
//  X_W / Y_W    $clog2(IMG_WIDTH) / $clog2(IMG_HEIGHT)  counter widths (localparam)
// PORTS
//  clk         in   1                       single clock, all state on rising edge
//  rst_n       in   1                       asynchronous, active-low reset
//  restart     in   1                       synchronous frame restart, single-cycle pulse
//  in_rgb      in   RGB_SIZE x NUM_ENGINES  batch from LUT (unpacked array [NUM_ENGINES-1:0])
//  in_valid    in   1                       batch valid
//  in_ready    out  1                       packer can accept a batch this cycle
//  out_data    out  RGB_SIZE                current pixel
//  out_valid   out  1                       out_data/out_sof/out_eol valid
//  out_ready   in   1                       sink accepts pixel
//  out_sof     out  1                       pixel is (x=0,y=0)
//  out_eol     out  1                       pixel is x=IMG_WIDTH-1
//  frame_done  out  1                       one-cycle pulse after last pixel of a frame is accepted
// BEHAVIOUR
//  - State: EMPTY (no batch held) / DRAIN (batch held, idx selects element). Registers: buf[], idx, x, y, state.
//  - Reset (rst_n=0): state=EMPTY, idx=0, x=0, y=0, buf=0, frame_done=0; hence out_valid=0, out_sof=0,
//    out_eol=0, out_data=0, in_ready=1.
//  - out_valid = (state==DRAIN); out_data = buf[idx]; out_sof = out_valid&&x==0&&y==0;
//    out_eol = out_valid&&x==IMG_WIDTH-1. All are functions of registers only; no input-to-output path.
//  - in_ready = (state==EMPTY) || (out_valid && out_ready && idx==NUM_ENGINES-1) || restart-free EMPTY.
//    in_ready depends combinationally on out_ready; in_valid never depends on in_ready (no loop).
//  - Load: in_valid&&in_ready -> buf<=in_rgb, idx<=0, state<=DRAIN. First pixel visible the next cycle (latency 1).
//  - Pixel accept (out_valid&&out_ready): idx<=idx+1; x<=x+1, or x<=0 and y<=y+1 at x==IMG_WIDTH-1;
//    at x==IMG_WIDTH-1 && y==IMG_HEIGHT-1: x<=0, y<=0, frame_done<=1 for exactly one cycle.
//  - Last element accepted (idx==NUM_ENGINES-1): if in_valid, reload in same cycle (no bubble);
//    otherwise state<=EMPTY, idx<=0.
//  - Stall: out_valid && !out_ready -> out_data, out_sof, out_eol, x, y, idx held stable; no batch accepted.
//  - Batches may straddle lines and frames: remaining elements continue at the wrapped position
//    (next line, or next frame with out_sof on the first pixel of the new frame).
//  - Sustained throughput: 1 pixel/cycle when in_valid and out_ready are held high.
//  - restart=1: state<=EMPTY, idx<=0, x<=0, y<=0, frame_done<=0. Any held batch is discarded.
//    restart overrides a simultaneous load or accept. in_ready=0 while restart=1.
//  - Reset asserted mid-batch: immediate return to reset values; partial batch lost.
//  - Widths: x, y compare with parameter-width constants; no overflow beyond IMG_WIDTH-1/IMG_HEIGHT-1.
// TESTING  (NUM_ENGINES=6, IMG_WIDTH=8, IMG_HEIGHT=2 unless noted)
//  1. After reset, one batch {0x000001..0x000006}, out_ready=1 -> 6 consecutive pixels 0x000001..0x000006.
//     out_sof on pixel 1 only, no eol. Then out_valid=0 and in_ready=1.
//  2. Three back-to-back batches, out_ready=1 -> 18 pixels with no gap cycle. eol at pixels 8 and 16.
//     sof at pixels 1 and 17. frame_done high 1 cycle after pixel 16.
//  3. Batch loaded, out_ready toggled 1,0,0,1,... -> every pixel seen exactly once in order.
//     out_data/sof/eol stable across stall cycles. in_ready=0 until the last element is accepted.
//  4. restart pulsed while idx=3 with in_valid=1 -> out_valid=0 next cycle and batch discarded.
//     The next batch starts with out_sof=1 at x=0,y=0.
//  5. rst_n dropped asynchronously mid-batch (no clock edge) -> out_valid=0 and in_ready=1 immediately.
//     After release, the first pixel carries out_sof.
//  6. IMG_WIDTH=640, IMG_HEIGHT=480, full frame at out_ready=1 -> 307200 pixels, 480 eol, 1 sof.
//     One frame_done pulse per frame.

Source files
------------

// File: rtl/pixel_stream_packer_if.sv
// Batch-in / pixel-out stream bundle between the colour LUT, the packer and the video sink.
// The master modport is the packer's view; the slave modport is the surrounding environment's view.
interface pixel_stream_packer_if #(
  parameter int RGB_SIZE    = 24,
  parameter int NUM_ENGINES = 6
);
  logic [RGB_SIZE-1:0] in_rgb [NUM_ENGINES-1:0];
  logic                in_valid;
  logic                in_ready;
  logic [RGB_SIZE-1:0] out_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_sof;
  logic                out_eol;

  modport master (
    input  in_rgb, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_sof, out_eol
  );

  modport slave (
    output in_rgb, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_sof, out_eol
  );
endinterface

// File: rtl/pixel_stream_packer.sv
// Captures a batch of NUM_ENGINES pixels and replays it one pixel per cycle on a ready/valid stream,
// tracking raster position to flag start-of-frame, end-of-line and frame completion.
module pixel_stream_packer #(
  parameter int RGB_SIZE    = 24,
  parameter int NUM_ENGINES = 6,
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  restart,
  pixel_stream_packer_if.master bus,
  output logic                  frame_done
);
  localparam int X_W   = (IMG_WIDTH   > 1) ? $clog2(IMG_WIDTH)   : 1;
  localparam int Y_W   = (IMG_HEIGHT  > 1) ? $clog2(IMG_HEIGHT)  : 1;
  localparam int IDX_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam logic [X_W-1:0]   X_LAST   = X_W'(IMG_WIDTH - 1);
  localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(IMG_HEIGHT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ENGINES - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t              state, state_next;
  logic [RGB_SIZE-1:0] pix_buf [NUM_ENGINES-1:0];
  logic [IDX_W-1:0]    idx, idx_next;
  logic [X_W-1:0]      x, x_next;
  logic [Y_W-1:0]      y, y_next;
  logic                frame_done_next;
  logic                accept;
  logic                last_elem;
  logic                load;

  assign bus.out_valid = (state == DRAIN);
  assign bus.out_data  = pix_buf[idx];
  assign bus.out_sof   = bus.out_valid && (x == '0) && (y == '0);
  assign bus.out_eol   = bus.out_valid && (x == X_LAST);

  // A new batch may enter while the final element of the current one leaves, giving back-to-back batches.
  assign accept       = bus.out_valid && bus.out_ready;
  assign last_elem    = (idx == IDX_LAST);
  assign bus.in_ready = !restart && ((state == EMPTY) || (accept && last_elem));
  assign load         = bus.in_valid && bus.in_ready;

  always_comb begin
    state_next      = state;
    idx_next        = idx;
    x_next          = x;
    y_next          = y;
    frame_done_next = 1'b0;

    if (accept) begin
      idx_next = idx + IDX_W'(1);
      if (x == X_LAST) begin
        x_next = '0;
        if (y == Y_LAST) begin
          y_next          = '0;
          frame_done_next = 1'b1;
        end else begin
          y_next = y + Y_W'(1);
        end
      end else begin
        x_next = x + X_W'(1);
      end
      if (last_elem) begin
        idx_next   = '0;
        state_next = EMPTY;
      end
    end

    if (load) begin
      idx_next   = '0;
      state_next = DRAIN;
    end

    // Restart wins over any simultaneous load or accept and drops whatever batch is held.
    if (restart) begin
      state_next      = EMPTY;
      idx_next        = '0;
      x_next          = '0;
      y_next          = '0;
      frame_done_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      idx        <= '0;
      x          <= '0;
      y          <= '0;
      frame_done <= 1'b0;
      for (int i = 0; i < NUM_ENGINES; i++) begin
        pix_buf[i] <= '0;
      end
    end else begin
      state      <= state_next;
      idx        <= idx_next;
      x          <= x_next;
      y          <= y_next;
      frame_done <= frame_done_next;
      if (load) begin
        for (int i = 0; i < NUM_ENGINES; i++) begin
          pix_buf[i] <= bus.in_rgb[i];
        end
      end
    end
  end
endmodule

// File: tb/tb_pixel_stream_packer.sv
// Bench for pixel_stream_packer on an 8x2 image: directed vector table, hand-written corner sequences,
// and randomized traffic scored against a queue-based model of the pixel stream.
module tb_pixel_stream_packer;
  localparam int RGB   = 24;
  localparam int NE    = 6;
  localparam int W     = 8;
  localparam int H     = 2;
  localparam int FRAME = W * H;

  typedef struct {
    logic            in_valid;
    logic            out_ready;
    logic            restart;
    logic            exp_valid;
    logic            exp_ready;
    logic            chk_data;
    logic [RGB-1:0]  exp_data;
    logic            exp_sof;
    logic            exp_eol;
  } vec_t;

  logic clk;
  logic rst_n;
  logic restart;
  logic frame_done;

  int errors;
  int checks;

  logic [RGB-1:0] q [$];
  int pos;
  bit fd_pending;
  int px_count, sof_count, eol_count, fd_count;
  int run_len, last_run;

  vec_t vecs [10];

  pixel_stream_packer_if #(.RGB_SIZE(RGB), .NUM_ENGINES(NE)) bus ();

  pixel_stream_packer #(
    .RGB_SIZE   (RGB),
    .NUM_ENGINES(NE),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart   (restart),
    .bus       (bus),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: a FIFO of pixels still owed to the sink plus the linear raster position of its head.
  task automatic run_monitor();
    bit accept;
    bit next_fd;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        pos        = 0;
        fd_pending = 0;
        run_len    = 0;
      end else begin
        check_output("out_valid", bus.out_valid, q.size() != 0);
        if (q.size() != 0) begin
          check_output("out_data", bus.out_data, q[0]);
          check_output("out_sof", bus.out_sof, pos == 0);
          check_output("out_eol", bus.out_eol, (pos % W) == W - 1);
        end
        check_output("in_ready", bus.in_ready,
                     !restart && (q.size() == 0 || (bus.out_ready && q.size() == 1)));
        check_output("frame_done", frame_done, fd_pending);

        accept = bus.out_valid && bus.out_ready;
        if (accept) begin
          px_count++;
          if (bus.out_sof) sof_count++;
          if (bus.out_eol) eol_count++;
          run_len++;
        end else begin
          if (run_len != 0) last_run = run_len;
          run_len = 0;
        end
        if (frame_done) fd_count++;

        if (restart) begin
          q.delete();
          pos        = 0;
          fd_pending = 0;
        end else begin
          next_fd = 0;
          if (accept && q.size() != 0) begin
            void'(q.pop_front());
            if (pos == FRAME - 1) next_fd = 1;
            pos = (pos + 1) % FRAME;
          end
          if (bus.in_valid && bus.in_ready) begin
            for (int k = 0; k < NE; k++) q.push_back(bus.in_rgb[k]);
          end
          fd_pending = next_fd;
        end
      end
    end
  endtask

  task automatic apply_stimulus(input logic iv, input logic ordy, input logic rs);
    bus.in_valid  = iv;
    bus.out_ready = ordy;
    restart       = rs;
  endtask

  task automatic send_batch(input logic [RGB-1:0] base);
    bit got;
    got = 0;
    @(posedge clk);
    #1;
    for (int k = 0; k < NE; k++) bus.in_rgb[k] = base + RGB'(k);
    bus.in_valid = 1'b1;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (bus.in_ready && !restart) got = 1;
    end
    check_output("send_timeout", got, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_output("drain_timeout", bus.out_valid, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int s_px, s_sof, s_eol, s_fd;
    logic [3:0] pattern;

    errors = 0;
    checks = 0;
    pos = 0;
    fd_pending = 0;
    px_count = 0; sof_count = 0; eol_count = 0; fd_count = 0;
    run_len = 0; last_run = 0;

    //            iv  ordy rs  ov  ir  chk data       sof eol
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 24'h000000, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 24'h000001, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 24'h000002, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 24'h000003, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 24'h000004, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 24'h000005, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 24'h000006, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0};

    rst_n = 1'b0;
    apply_stimulus(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < NE; k++) bus.in_rgb[k] = RGB'(k + 1);
    fork
      run_monitor();
    join_none

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_out_valid", bus.out_valid, 0);
    check_output("rst_in_ready", bus.in_ready, 1);
    check_output("rst_out_data", bus.out_data, 0);
    check_output("rst_sof", bus.out_sof, 0);
    check_output("rst_eol", bus.out_eol, 0);
    check_output("rst_frame_done", frame_done, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single batch walked cycle by cycle, then a restart that must block a pending load.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      apply_stimulus(vecs[i].in_valid, vecs[i].out_ready, vecs[i].restart);
      @(negedge clk);
      check_output($sformatf("vec%0d_valid", i), bus.out_valid, vecs[i].exp_valid);
      check_output($sformatf("vec%0d_ready", i), bus.in_ready, vecs[i].exp_ready);
      if (vecs[i].chk_data) begin
        check_output($sformatf("vec%0d_data", i), bus.out_data, vecs[i].exp_data);
        check_output($sformatf("vec%0d_sof", i), bus.out_sof, vecs[i].exp_sof);
        check_output($sformatf("vec%0d_eol", i), bus.out_eol, vecs[i].exp_eol);
      end
    end
    @(posedge clk);
    #1;
    apply_stimulus(1'b0, 1'b1, 1'b0);

    // Three back-to-back batches straddling a line and a frame boundary.
    s_px = px_count; s_sof = sof_count; s_eol = eol_count; s_fd = fd_count;
    send_batch(24'h000010);
    send_batch(24'h000020);
    send_batch(24'h000030);
    wait_drain();
    check_output("b2b_pixels", px_count - s_px, 18);
    check_output("b2b_sof", sof_count - s_sof, 2);
    check_output("b2b_eol", eol_count - s_eol, 2);
    check_output("b2b_frame_done", fd_count - s_fd, 1);
    check_output("b2b_no_gap", last_run, 18);

    // Backpressure with out_ready cycling 1,0,0,1.
    s_px = px_count;
    pattern = 4'b1001;
    fork
      send_batch(24'h000040);
      begin
        for (int i = 0; i < 24; i++) begin
          @(posedge clk);
          #1;
          bus.out_ready = pattern[i % 4];
        end
      end
    join
    bus.out_ready = 1'b1;
    wait_drain();
    check_output("stall_pixels", px_count - s_px, 6);

    // Restart while idx==3 with a new batch offered.
    send_batch(24'h000050);
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NE; k++) bus.in_rgb[k] = 24'h000100 + RGB'(k);
    bus.in_valid = 1'b1;
    restart = 1'b1;
    @(negedge clk);
    check_output("rs_in_ready", bus.in_ready, 0);
    check_output("rs_held_data", bus.out_data, 24'h000053);
    @(posedge clk);
    #1;
    restart = 1'b0;
    @(negedge clk);
    check_output("rs_discard", bus.out_valid, 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_output("rs_new_valid", bus.out_valid, 1);
    check_output("rs_new_sof", bus.out_sof, 1);
    check_output("rs_new_data", bus.out_data, 24'h000100);
    wait_drain();

    // Asynchronous reset mid-batch, away from any clock edge.
    send_batch(24'h000200);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_output("arst_out_valid", bus.out_valid, 0);
    check_output("arst_in_ready", bus.in_ready, 1);
    check_output("arst_sof", bus.out_sof, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_batch(24'h000300);
    @(negedge clk);
    check_output("arst_first_sof", bus.out_sof, 1);
    check_output("arst_first_data", bus.out_data, 24'h000300);
    wait_drain();

    // Randomized traffic with occasional restarts.
    for (int i = 0; i < 800; i++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NE; k++) bus.in_rgb[k] = RGB'($urandom);
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      restart       = ($urandom_range(0, 99) == 0);
    end
    @(posedge clk);
    #1;
    apply_stimulus(1'b0, 1'b1, 1'b0);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
